adder_arbiter_16b: RTL and testbench

ADDER_ARBITER_16B -- requirements
Module: adder_arbiter_16b

---
 rtl/adder_arbiter_pkg.sv | 12 +
 rtl/adder_16b.sv | 12 +
 rtl/adder_arbiter_16b.sv | 133 +++++++++++++
 tb/tb_adder_arbiter_16b.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared state encoding and requester count for adder_arbiter_16b
package adder_arbiter_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/adder_16b.sv
// rtl/adder_16b.sv - 16-bit adder with carry-in and carry-out
module adder_16b (
   input  logic [15:0] in0,
   input  logic [15:0] in1,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, in0} + {1'b0, in1} + {16'd0, cin};

endmodule

// File: rtl/adder_arbiter_16b.sv
// rtl/adder_arbiter_16b.sv - two-requester arbitrated 16-bit adder, IDLE/CALC/RESP per result
// Optional build macro ADDER_ARBITER_ROUND_ROBIN_EN enables round-robin arbitration on contention.
module adder_arbiter_16b
   import adder_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_val,
   output logic [NUM_REQ-1:0] req_rdy,
   input  logic [15:0]        req0_in0,
   input  logic [15:0]        req0_in1,
   input  logic               req0_cin,
   input  logic [15:0]        req1_in0,
   input  logic [15:0]        req1_in1,
   input  logic               req1_cin,
   output logic [NUM_REQ-1:0] resp_val,
   input  logic [NUM_REQ-1:0] resp_rdy,
   output logic [15:0]        resp_sum,
   output logic               resp_cout
);

   state_t      state_q, state_d;
   logic        grant;
   logic        xfer;
   logic [15:0] in0_q, in1_q;
   logic        cin_q;
   logic        grant_q;
   logic [15:0] sum_q;
   logic        cout_q;
   logic [15:0] add_sum;
   logic        add_cout;

`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
   logic last_grant_q;

   // Resets to 1 so the first contended grant goes to requester 0.
   always_ff @(posedge clk) begin
      if (rst)
         last_grant_q <= 1'b1;
      else if (xfer)
         last_grant_q <= grant;
   end

   always_comb begin
      grant = 1'b0;
      if (req_val[0] && req_val[1])
         grant = ~last_grant_q;
      else
         grant = req_val[1];
   end
`else
   always_comb begin
      grant = 1'b0;
      if (req_val[0] && req_val[1])
         grant = 1'b0;
      else
         grant = req_val[1];
   end
`endif

   assign xfer = |(req_val & req_rdy);

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_rdy   = '0;
      resp_val  = '0;
      resp_sum  = '0;
      resp_cout = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_val) begin
               req_rdy[grant] = 1'b1;
               state_d        = CALC;
            end
         end
         CALC: state_d = RESP;
         RESP: begin
            resp_val[grant_q] = 1'b1;
            resp_sum          = sum_q;
            resp_cout         = cout_q;
            if (resp_rdy[grant_q])
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs are forced quiet for the whole reset cycle, not only after the edge.
      if (rst) begin
         state_d   = IDLE;
         req_rdy   = '0;
         resp_val  = '0;
         resp_sum  = '0;
         resp_cout = 1'b0;
      end
   end

   adder_16b u_adder (
      .in0  (in0_q),
      .in1  (in1_q),
      .cin  (cin_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         in0_q   <= '0;
         in1_q   <= '0;
         cin_q   <= 1'b0;
         grant_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         if (xfer) begin
            grant_q <= grant;
            in0_q   <= grant ? req1_in0 : req0_in0;
            in1_q   <= grant ? req1_in1 : req0_in1;
            cin_q   <= grant ? req1_cin : req0_cin;
         end
         if (state_q == CALC) begin
            sum_q  <= add_sum;
            cout_q <= add_cout;
         end
      end
   end

endmodule

// File: tb/tb_adder_arbiter_16b.sv
// tb/tb_adder_arbiter_16b.sv - directed self-checking bench for adder_arbiter_16b
module tb_adder_arbiter_16b;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_val;
   logic [1:0]  req_rdy;
   logic [15:0] req0_in0, req0_in1, req1_in0, req1_in1;
   logic        req0_cin, req1_cin;
   logic [1:0]  resp_val;
   logic [1:0]  resp_rdy;
   logic [15:0] resp_sum;
   logic        resp_cout;

   int vectors = 0;
   int miscompares = 0;

   adder_arbiter_16b dut (
      .clk       (clk),
      .rst       (rst),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .req0_in0  (req0_in0),
      .req0_in1  (req0_in1),
      .req0_cin  (req0_cin),
      .req1_in0  (req1_in0),
      .req1_in1  (req1_in1),
      .req1_cin  (req1_cin),
      .resp_val  (resp_val),
      .resp_rdy  (resp_rdy),
      .resp_sum  (resp_sum),
      .resp_cout (resp_cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_val = 2'b11; resp_rdy = 2'b11;
      req0_in0 = 16'h1111; req0_in1 = 16'h2222; req0_cin = 1'b1;
      req1_in0 = 16'h3333; req1_in1 = 16'h4444; req1_cin = 1'b1;
      tick(); tick();
      vectors++;
      if (req_rdy !== 2'b00) begin
         miscompares++; $display("FAIL reset_req_rdy got %b want 00", req_rdy);
      end
      vectors++;
      if (resp_val !== 2'b00 || resp_sum !== 16'h0000 || resp_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_resp got val=%b sum=%h cout=%b want 00/0000/0", resp_val, resp_sum, resp_cout);
      end
      req_val = 2'b00; resp_rdy = 2'b00;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_single();
      req_val = 2'b01; req0_in0 = 16'h0003; req0_in1 = 16'h0004; req0_cin = 1'b1; resp_rdy = 2'b01;
      #1;
      vectors++;
      if (req_rdy !== 2'b01) begin
         miscompares++; $display("FAIL single_req_rdy got %b want 01", req_rdy);
      end
      tick();
      req_val = 2'b00;
      #1;
      vectors++;
      if (resp_val !== 2'b00 || req_rdy !== 2'b00) begin
         miscompares++; $display("FAIL single_calc got val=%b rdy=%b want 00/00", resp_val, req_rdy);
      end
      tick();
      vectors++;
      if (resp_val !== 2'b01 || resp_sum !== 16'h0008 || resp_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL single_resp got val=%b sum=%h cout=%b want 01/0008/0", resp_val, resp_sum, resp_cout);
      end
      tick();
      vectors++;
      if (resp_val !== 2'b00 || resp_sum !== 16'h0000 || resp_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL single_idle got val=%b sum=%h cout=%b want 00/0000/0", resp_val, resp_sum, resp_cout);
      end
   endtask

   task automatic test_overflow();
      req_val = 2'b10; req1_in0 = 16'hFFFF; req1_in1 = 16'h0001; req1_cin = 1'b0; resp_rdy = 2'b10;
      #1;
      vectors++;
      if (req_rdy !== 2'b10) begin
         miscompares++; $display("FAIL ovf_req_rdy got %b want 10", req_rdy);
      end
      tick();
      req_val = 2'b00;
      tick();
      vectors++;
      if (resp_val !== 2'b10 || resp_sum !== 16'h0000 || resp_cout !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_resp got val=%b sum=%h cout=%b want 10/0000/1", resp_val, resp_sum, resp_cout);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [1:0]  exp_g [3];
      logic [15:0] exp_s;
      logic        exp_c;
      rst = 1'b1; req_val = 2'b00; resp_rdy = 2'b00;
      tick();
      rst = 1'b0;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`endif
      req0_in0 = 16'h0100; req0_in1 = 16'h0020; req0_cin = 1'b0;
      req1_in0 = 16'h0A00; req1_in1 = 16'h00B0; req1_cin = 1'b1;
      req_val = 2'b11; resp_rdy = 2'b11;
      #1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (req_rdy !== exp_g[k]) begin
            miscompares++; $display("FAIL contend_grant%0d got %b want %b", k, req_rdy, exp_g[k]);
         end
         exp_s = (exp_g[k] == 2'b01) ? 16'h0120 : 16'h0AB1;
         exp_c = 1'b0;
         tick(); tick();
         vectors++;
         if (resp_val !== exp_g[k] || resp_sum !== exp_s || resp_cout !== exp_c) begin
            miscompares++;
            $display("FAIL contend_resp%0d got val=%b sum=%h cout=%b want %b/%h/%b",
                     k, resp_val, resp_sum, resp_cout, exp_g[k], exp_s, exp_c);
         end
         tick();
      end
      req_val = 2'b00; resp_rdy = 2'b00;
      tick(); tick(); tick();
   endtask

   task automatic test_backpressure();
      req_val = 2'b01; req0_in0 = 16'h8000; req0_in1 = 16'h8001; req0_cin = 1'b1; resp_rdy = 2'b00;
      tick();
      tick();
      req_val = 2'b11;
      for (int k = 0; k < 5; k++) begin
         resp_rdy = (k >= 3) ? 2'b10 : 2'b00;
         #1;
         vectors++;
         if (resp_val !== 2'b01 || resp_sum !== 16'h0002 || resp_cout !== 1'b1 || req_rdy !== 2'b00) begin
            miscompares++;
            $display("FAIL backpressure%0d got val=%b sum=%h cout=%b rdy=%b want 01/0002/1/00",
                     k, resp_val, resp_sum, resp_cout, req_rdy);
         end
         tick();
      end
      req_val = 2'b00; resp_rdy = 2'b01;
      tick();
      resp_rdy = 2'b00;
      #1;
      vectors++;
      if (resp_val !== 2'b00 || resp_sum !== 16'h0000 || req_rdy !== 2'b00) begin
         miscompares++;
         $display("FAIL bp_release got val=%b sum=%h rdy=%b want 00/0000/00", resp_val, resp_sum, req_rdy);
      end
      req_val = 2'b10; req1_in0 = 16'h0001; req1_in1 = 16'h0001; req1_cin = 1'b0;
      #1;
      vectors++;
      if (req_rdy !== 2'b10) begin
         miscompares++; $display("FAIL bp_idle_accept got %b want 10", req_rdy);
      end
      req_val = 2'b00;
      #1;
   endtask

   task automatic test_reset_mid();
      logic seen;
      req_val = 2'b01; req0_in0 = 16'h0010; req0_in1 = 16'h0020; req0_cin = 1'b0; resp_rdy = 2'b01;
      tick();
      req_val = 2'b00;
      rst = 1'b1;
      #1;
      vectors++;
      if (req_rdy !== 2'b00 || resp_val !== 2'b00) begin
         miscompares++; $display("FAIL rstmid_during got rdy=%b val=%b want 00/00", req_rdy, resp_val);
      end
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (resp_val !== 2'b00) seen = 1'b1;
         tick();
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_no_resp got pulse=%b want 0", seen);
      end
      req_val = 2'b01; req0_in0 = 16'h1000; req0_in1 = 16'h0234; req0_cin = 1'b1;
      #1;
      vectors++;
      if (req_rdy !== 2'b01) begin
         miscompares++; $display("FAIL rstmid_accept got %b want 01", req_rdy);
      end
      tick();
      req_val = 2'b00;
      tick();
      vectors++;
      if (resp_val !== 2'b01 || resp_sum !== 16'h1235 || resp_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_after got val=%b sum=%h cout=%b want 01/1235/0", resp_val, resp_sum, resp_cout);
      end
      tick();
   endtask

   task automatic test_operand_change();
      req_val = 2'b01; req0_in0 = 16'h1234; req0_in1 = 16'h1111; req0_cin = 1'b0; resp_rdy = 2'b01;
      tick();
      req0_in0 = 16'hFFFF; req0_in1 = 16'hFFFF; req0_cin = 1'b1;
      req_val = 2'b00;
      tick();
      vectors++;
      if (resp_val !== 2'b01 || resp_sum !== 16'h2345 || resp_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL opchange got val=%b sum=%h cout=%b want 01/2345/0", resp_val, resp_sum, resp_cout);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_operand_change();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
